// File: rtl/req_arrival_queue_pkg.sv
// Shared helpers for the request arrival queue: depth derivation,
// lowest-set-bit one-hot pick and population count.
package req_arrival_queue_pkg;

    // Widest request vector the helper functions handle; callers zero-extend.
    localparam int unsigned MAX_W = 64;
    // Bits needed to hold a popcount of MAX_W bits (0..64).
    localparam int unsigned CNT_W = 7;

    // Number of queue entries for a given address width.
    function automatic int unsigned fifo_depth(input int unsigned widthu);
        return 32'd1 << widthu;
    endfunction

    // One-hot of the lowest-index set bit; bit 0 wins. Zero in, zero out.
    function automatic logic [MAX_W-1:0] lowest_one_hot(input logic [MAX_W-1:0] v);
        return v & (~v + MAX_W'(1));
    endfunction

    // Count of set bits in v.
    function automatic logic [CNT_W-1:0] popcount(input logic [MAX_W-1:0] v);
        logic [CNT_W-1:0] cnt;
        cnt = CNT_W'(0);
        for (int i = 0; i < int'(MAX_W); i++) begin
            cnt = cnt + CNT_W'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/req_fifo_core.sv
// Circular-buffer storage for request vectors with show-ahead head output.
// Flags and usedw derive from the count register; q reads 0 while empty.
module req_fifo_core
    import req_arrival_queue_pkg::*;
#(
    parameter int unsigned WIDTH  = 2,
    parameter int unsigned WIDTHU = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              sclr_i,
    input  logic              wrreq_i,
    input  logic [WIDTH-1:0]  data_i,
    input  logic              rdreq_i,
    output logic              empty_o,
    output logic              full_o,
    output logic [WIDTHU:0]   usedw_o,
    output logic [WIDTH-1:0]  q_o
);

    localparam int unsigned DEPTH = fifo_depth(WIDTHU);
    localparam int unsigned CW    = WIDTHU + 1;

    logic [WIDTH-1:0]  mem_q [0:DEPTH-1];
    logic [WIDTHU-1:0] wr_ptr_q, wr_ptr_d;
    logic [WIDTHU-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q,  count_d;
    logic              empty_s;
    logic              full_s;
    logic              push_ok_s;
    logic              pop_ok_s;

    assign empty_s = (count_q == CW'(0));
    assign full_s  = (count_q == CW'(DEPTH));
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign pop_ok_s  = rdreq_i && !empty_s;
    assign push_ok_s = wrreq_i && (!full_s || pop_ok_s);

    // Next-state for pointers and count; reset discards everything.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (sclr_i) begin
            wr_ptr_d = WIDTHU'(0);
            rd_ptr_d = WIDTHU'(0);
            count_d  = CW'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_d = wr_ptr_q + WIDTHU'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_ok_s) begin
                rd_ptr_d = rd_ptr_q + WIDTHU'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (sclr_i) begin
            wr_ptr_q <= WIDTHU'(0);
            rd_ptr_q <= WIDTHU'(0);
            count_q  <= CW'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents are not cleared by reset since q is gated.
    always_ff @(posedge clk) begin
        if (!sclr_i && push_ok_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign empty_o = empty_s;
    assign full_o  = full_s;
    assign usedw_o = count_q;
    assign q_o     = empty_s ? WIDTH'(0) : mem_q[rd_ptr_q];

endmodule

// File: rtl/req_arrival_queue.sv
// First-come-first-served queue of per-channel request vectors with
// head popcount and lowest-index priority decode, plus a free-standing
// priority picker for the consumer's residual mask.
module req_arrival_queue
    import req_arrival_queue_pkg::*;
#(
    parameter int unsigned WIDTH  = 2,
    parameter int unsigned WIDTHU = $clog2(WIDTH)
) (
    input  logic                         clk,
    input  logic                         sclr,
    input  logic                         wrreq,
    input  logic [WIDTH-1:0]             data,
    input  logic                         rdreq,
    output logic                         empty,
    output logic                         full,
    output logic [WIDTHU:0]              usedw,
    output logic [WIDTH-1:0]             q,
    output logic [$clog2(WIDTH+1)-1:0]   q_cnt,
    output logic [WIDTH-1:0]             q_pri,
    input  logic [WIDTH-1:0]             pri_in,
    output logic [WIDTH-1:0]             pri_out
);

    localparam int unsigned QCW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] q_s;

    req_fifo_core #(
        .WIDTH  (WIDTH),
        .WIDTHU (WIDTHU)
    ) u_core (
        .clk     (clk),
        .sclr_i  (sclr),
        .wrreq_i (wrreq),
        .data_i  (data),
        .rdreq_i (rdreq),
        .empty_o (empty),
        .full_o  (full),
        .usedw_o (usedw),
        .q_o     (q_s)
    );

    assign q       = q_s;
    assign q_cnt   = QCW'(popcount(MAX_W'(q_s)));
    assign q_pri   = WIDTH'(lowest_one_hot(MAX_W'(q_s)));
    assign pri_out = WIDTH'(lowest_one_hot(MAX_W'(pri_in)));

endmodule

// File: tb/tb_req_arrival_queue.sv
// Bench for req_arrival_queue (WIDTH=4, depth 4): directed plan steps then
// random traffic, all checked against a queue-based reference model.
module tb_req_arrival_queue;

    localparam int W = 4;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         sclr = 1'b0;
    logic         wrreq = 1'b0;
    logic [W-1:0] data = '0;
    logic         rdreq = 1'b0;
    logic         empty;
    logic         full;
    logic [2:0]   usedw;
    logic [W-1:0] q;
    logic [2:0]   q_cnt;
    logic [W-1:0] q_pri;
    logic [W-1:0] pri_in = '0;
    logic [W-1:0] pri_out;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [W-1:0] mq[$];

    req_arrival_queue #(.WIDTH(W)) dut (
        .clk     (clk),
        .sclr    (sclr),
        .wrreq   (wrreq),
        .data    (data),
        .rdreq   (rdreq),
        .empty   (empty),
        .full    (full),
        .usedw   (usedw),
        .q       (q),
        .q_cnt   (q_cnt),
        .q_pri   (q_pri),
        .pri_in  (pri_in),
        .pri_out (pri_out)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_pri(input logic [W-1:0] v);
        for (int i = 0; i < W; i++) begin
            if (v[i]) return W'(1) << i;
        end
        return '0;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model.
    task automatic check_all();
        logic [W-1:0] hq;
        hq = (mq.size() > 0) ? mq[0] : '0;
        check("empty",   int'(empty),   int'(mq.size() == 0));
        check("full",    int'(full),    int'(mq.size() == D));
        check("usedw",   int'(usedw),   mq.size());
        check("q",       int'(q),       int'(hq));
        check("q_cnt",   int'(q_cnt),   $countones(hq));
        check("q_pri",   int'(q_pri),   int'(ref_pri(hq)));
        check("pri_out", int'(pri_out), int'(ref_pri(pri_in)));
    endtask

    // One clock: drive inputs, advance the model, check after the edge.
    task automatic step(input logic wr, input logic [W-1:0] d, input logic rd,
                        input logic sc);
        bit do_pop, do_push;
        wrreq = wr; data = d; rdreq = rd; sclr = sc;
        @(posedge clk);
        if (sc) begin
            mq.delete();
        end else begin
            do_pop  = rd && (mq.size() > 0);
            do_push = wr && ((mq.size() < D) || do_pop);
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back(d);
        end
        #1;
        check_all();
    endtask

    initial begin
        // Reset then idle.
        step(1'b0, 4'h0, 1'b0, 1'b1);
        step(1'b0, 4'h0, 1'b0, 1'b0);
        check("rst_empty", int'(empty), 1);
        check("rst_q", int'(q), 0);

        // Single push then pop.
        step(1'b1, 4'b0110, 1'b0, 1'b0);
        check("p1_q", int'(q), 4'b0110);
        check("p1_cnt", int'(q_cnt), 2);
        check("p1_pri", int'(q_pri), 4'b0010);
        step(1'b0, 4'h0, 1'b1, 1'b0);
        check("p1_pop_empty", int'(empty), 1);

        // Fill to depth, overflow push ignored.
        step(1'b1, 4'b0001, 1'b0, 1'b0);
        step(1'b1, 4'b1010, 1'b0, 1'b0);
        step(1'b1, 4'b1111, 1'b0, 1'b0);
        step(1'b1, 4'b0100, 1'b0, 1'b0);
        check("fill_full", int'(full), 1);
        step(1'b1, 4'b1000, 1'b0, 1'b0);
        check("ovf_usedw", int'(usedw), 4);
        check("ovf_head", int'(q), 4'b0001);

        // Simultaneous push/pop while full keeps count and order.
        step(1'b1, 4'b1001, 1'b1, 1'b0);
        check("fullpp_usedw", int'(usedw), 4);
        check("fullpp_head", int'(q), 4'b1010);

        // Drain in order.
        for (int i = 0; i < 4; i++) step(1'b0, 4'h0, 1'b1, 1'b0);
        check("drain_empty", int'(empty), 1);
        step(1'b0, 4'h0, 1'b1, 1'b0);   // pop while empty ignored

        // Simultaneous push/pop while empty: push only.
        step(1'b1, 4'b0011, 1'b1, 1'b0);
        check("emptypp_q", int'(q), 4'b0011);
        check("emptypp_usedw", int'(usedw), 1);

        // pri_in sweep.
        pri_in = 4'b0000; #1; check("pri_0000", int'(pri_out), 4'b0000);
        pri_in = 4'b1100; #1; check("pri_1100", int'(pri_out), 4'b0100);
        pri_in = 4'b1011; #1; check("pri_1011", int'(pri_out), 4'b0001);
        pri_in = 4'b1000; #1; check("pri_1000", int'(pri_out), 4'b1000);

        // Reset with a write pending while holding 3 entries.
        step(1'b1, 4'b0101, 1'b0, 1'b0);
        step(1'b1, 4'b0111, 1'b0, 1'b0);
        check("pre_sclr_usedw", int'(usedw), 3);
        step(1'b1, 4'b1110, 1'b0, 1'b1);
        check("sclr_usedw", int'(usedw), 0);
        check("sclr_q", int'(q), 0);
        step(1'b0, 4'h0, 1'b0, 1'b0);
        check("sclr_nowrite", int'(empty), 1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            pri_in = W'($urandom);
            step(1'($urandom_range(0, 99) < 55), W'($urandom),
                 1'($urandom_range(0, 99) < 45),
                 1'($urandom_range(0, 99) < 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
